multi_timer: RTL and testbench

MULTI_TIMER -- requirements
Module: multi_timer

---
 rtl/multi_timer.sv | 108 ++++++++++
 tb/tb_multi_timer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// Multi-channel match timer with per-channel limit, mode and interrupt.
// Define MULTI_TIMER_PRESCALER_EN to add a per-channel clock prescaler.
module multi_timer #(
  parameter int NUM_CH  = 2,
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CW-1:0]    wr_ch,
  input  logic [1:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [CW-1:0]    rd_ch,
  output logic [WIDTH-1:0] rd_count,
  output logic [NUM_CH-1:0] timer_irq,
  output logic             irq_any
);

  logic [WIDTH-1:0] counts [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] lim;
    logic en;
    logic periodic;
    logic ie;
    logic pending;
    logic hit;
    logic ctrl_wr;
    logic restart;
    logic tick;
    logic match;

    assign hit     = wr_en && (wr_ch == CW'(i));
    assign ctrl_wr = hit && (wr_sel == 2'd0);
    assign restart = ctrl_wr && wr_data[3];

`ifdef MULTI_TIMER_PRESCALER_EN
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pcnt;

    assign tick = en && (pcnt == presc);

    always_ff @(posedge clk) begin
      if (rst) begin
        presc <= '0;
        pcnt  <= '0;
      end else begin
        if (hit && wr_sel == 2'd3)
          presc <= wr_data[PRESC_W-1:0];
        if (!en || restart || tick)
          pcnt <= '0;
        else
          pcnt <= pcnt + 1'b1;
      end
    end
`else
    assign tick = en;
`endif

    assign match = tick && (cnt == lim);

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt      <= '0;
        lim      <= '0;
        en       <= 1'b0;
        periodic <= 1'b0;
        ie       <= 1'b0;
        pending  <= 1'b0;
      end else begin
        if (restart || match)
          cnt <= '0;
        else if (tick)
          cnt <= cnt + 1'b1;
        if (hit && wr_sel == 2'd1)
          lim <= wr_data;
        // A CTRL write beats the one-shot auto-disable
        if (ctrl_wr) begin
          en       <= wr_data[0];
          periodic <= wr_data[1];
          ie       <= wr_data[2];
        end else if (match && !periodic) begin
          en <= 1'b0;
        end
        if (match)
          pending <= 1'b1;
        else if (hit && wr_sel == 2'd2)
          pending <= 1'b0;
      end
    end

    assign counts[i]    = cnt;
    assign timer_irq[i] = pending && ie;
  end

  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_ch == CW'(i))
        rd_count = counts[i];
  end

  assign irq_any = |timer_irq;

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: stimulus queues timed
// expectations, a negedge monitor pops and compares them.
module tb_multi_timer;
  localparam int NC = 3;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [1:0]    wr_ch;
  logic [1:0]    wr_sel;
  logic [W-1:0]  wr_data;
  logic [1:0]    rd_ch;
  logic [W-1:0]  rd_count;
  logic [NC-1:0] timer_irq;
  logic          irq_any;

  typedef struct {
    int    cyc;
    int    kind;
    int    val;
    string name;
  } item_t;

  item_t q[$];
  item_t it;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int got;

  multi_timer #(.NUM_CH(NC), .WIDTH(W), .PRESC_W(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_sel(wr_sel), .wr_data(wr_data), .rd_ch(rd_ch),
    .rd_count(rd_count), .timer_irq(timer_irq),
    .irq_any(irq_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // kind 0: rd_count, 1: timer_irq, 2: irq_any
  task automatic exp_at(int dc, int kind, int val, string name);
    item_t e;
    int k;
    e.cyc = cyc + dc;
    e.kind = kind;
    e.val = val;
    e.name = name;
    k = q.size();
    while (k > 0 && q[k-1].cyc > e.cyc) k--;
    q.insert(k, e);
  endtask

  task automatic exp_irq(int dc, int val, string name);
    exp_at(dc, 1, val, name);
    exp_at(dc, 2, (val != 0) ? 1 : 0, {name, "_any"});
  endtask

  task automatic wr(int ch, int sel, int d);
    wr_en = 1'b1;
    wr_ch = 2'(ch);
    wr_sel = 2'(sel);
    wr_data = W'(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      it = q.pop_front();
      case (it.kind)
        0: got = int'(rd_count);
        1: got = int'(timer_irq);
        default: got = int'(irq_any);
      endcase
      n_chk++;
      if (it.cyc != cyc || got != it.val) begin
        n_fail++;
        $display("FAIL %s cyc=%0d due=%0d got=%0d exp=%0d",
                 it.name, cyc, it.cyc, got, it.val);
      end
    end
  end

  int p;

  initial begin
`ifdef MULTI_TIMER_PRESCALER_EN
    p = 12;
`else
    p = 3;
`endif
    rst = 1'b1;
    wr_en = 1'b0;
    wr_ch = '0;
    wr_sel = '0;
    wr_data = '0;
    rd_ch = 2'd0;
    idle(2);
    rst = 1'b0;
    exp_at(0, 0, 0, "rst_cnt");
    exp_irq(0, 0, "rst_irq");

    // periodic ch0 with clear/set collision
    idle(1);
    wr(0, 1, 10);
    wr(0, 0, 7);
    exp_at(10, 0, 10, "p_cnt10");
    exp_irq(10, 0, "p_pre");
    exp_irq(11, 1, "p_hit");
    exp_at(11, 0, 0, "p_wrap");
    exp_at(12, 0, 1, "p_cont");
    exp_irq(12, 0, "clr_drop");
    exp_irq(21, 0, "p2_pre");
    exp_irq(22, 1, "clr_lose");
    exp_irq(23, 0, "clr_late");
    idle(11);
    wr(0, 2, 0);
    idle(9);
    wr(0, 2, 0);
    wr(0, 2, 0);
    wr(0, 0, 0);
    idle(2);

    // one-shot ch1
    rd_ch = 2'd1;
    wr(1, 1, 3);
    wr(1, 0, 5);
    exp_at(3, 0, 3, "os_cnt3");
    exp_irq(3, 0, "os_pre");
    exp_irq(4, 2, "os_hit");
    exp_at(4, 0, 0, "os_zero");
    exp_at(8, 0, 0, "os_hold");
    exp_irq(8, 2, "os_once");
    idle(8);
    wr(1, 2, 0);
    exp_irq(0, 0, "os_clr");
    idle(1);

    // out-of-range channel
    rd_ch = 2'd3;
    wr(3, 1, 0);
    wr(3, 0, 7);
    exp_at(0, 0, 0, "bad_rd");
    exp_irq(3, 0, "bad_wr");
    idle(4);

    // prescaler / restart on ch0
    rd_ch = 2'd0;
    wr(0, 3, 3);
    wr(0, 1, 2);
    wr(0, 0, 15);
    exp_at(0, 0, 0, "restart");
    exp_irq(p - 1, 0, "ps_pre");
    exp_irq(p, 1, "ps_hit");
    exp_irq(p + 1, 0, "ps_clr");
    exp_irq(2 * p - 1, 0, "ps_pre2");
    exp_irq(2 * p, 1, "ps_hit2");
    idle(p);
    wr(0, 2, 0);
    idle(p);
    wr(0, 0, 0);
    wr(0, 2, 0);
    exp_irq(0, 0, "ps_off");
    idle(1);

    // wrap: count 200, limit 5
    rd_ch = 2'd1;
    wr(1, 1, 250);
    wr(1, 0, 1);
    idle(199);
    wr(1, 0, 0);
    exp_at(0, 0, 200, "wr_200");
    exp_at(3, 0, 200, "wr_idle");
    idle(3);
    wr(1, 1, 5);
    exp_at(0, 0, 200, "lim_below");
    wr(1, 0, 5);
    exp_at(55, 0, 255, "wr_255");
    exp_at(56, 0, 0, "wr_0");
    exp_at(61, 0, 5, "wr_5");
    exp_irq(61, 0, "wr_pre");
    exp_irq(62, 2, "wr_hit");
    exp_at(62, 0, 0, "wr_load0");
    idle(62);
    wr(1, 2, 0);
    exp_irq(0, 0, "wr_clr");
    idle(1);

    // reset mid-count on ch0
    rd_ch = 2'd0;
    wr(0, 3, 0);
    wr(0, 1, 0);
    wr(0, 0, 15);
    wr(0, 1, 50);
    exp_at(7, 0, 7, "mid_cnt7");
    exp_irq(7, 1, "mid_pend");
    idle(7);
    rst = 1'b1;
    wr(0, 0, 7);
    rst = 1'b0;
    exp_at(0, 0, 0, "mr_cnt");
    exp_irq(0, 0, "mr_irq");
    exp_at(5, 0, 0, "mr_idle");
    idle(5);
    wr(0, 0, 5);
    exp_irq(0, 0, "lim0_pre");
    exp_irq(1, 1, "lim0_hit");
    exp_at(1, 0, 0, "lim0_cnt");
    exp_at(3, 0, 0, "lim0_stop");
    idle(4);

    idle(3);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
